// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
//   Shared definitions for the parallel ADC capture block:
//     - state_t          : one-hot capture FSM state encoding
//     - *_STRAP          : constant levels for the ADC mode strap pins
//     - BUSY_TIMEOUT_*   : BUSY wait limit used when ADC_BUSY_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package adc_pkg;

    typedef enum logic [7:0] {
        CFG_W0  = 8'b0000_0001,
        CFG_W1  = 8'b0000_0010,
        IDLE    = 8'b0000_0100,
        CONV    = 8'b0000_1000,
        WAIT_HI = 8'b0001_0000,
        WAIT_LO = 8'b0010_0000,
        RD      = 8'b0100_0000,
        PUSH    = 8'b1000_0000
    } state_t;

    // Hardware mode off, parallel interface, not in standby.
    localparam logic HW_N_STRAP   = 1'b1;
    localparam logic PAR_N_STRAP  = 1'b0;
    localparam logic STBY_N_STRAP = 1'b1;

    // Combined cycles allowed in WAIT_HI + WAIT_LO before giving up on BUSY.
    localparam int BUSY_TIMEOUT_CYC = 1024;
    localparam int BUSY_TIMEOUT_W   = $clog2(BUSY_TIMEOUT_CYC);

endpackage

// File: rtl/adc_strobe_timer.sv
// -----------------------------------------------------------------------------
// adc_strobe_timer
//   Phase timer shared by the WR_N, RD_N and CONVST strobes. While en is high
//   it runs a repeating 2*PULSE_CYC cycle window: PULSE_CYC cycles of active
//   phase followed by PULSE_CYC cycles of inactive phase. Dropping en restarts
//   the window, so a new strobe always begins with its active phase.
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-low reset
//     en       in   run the window (owner state is active)
//     low      out  active phase (strobe asserted)
//     last_low out  final cycle of the active phase
//     done     out  final cycle of the inactive phase (window complete)
// -----------------------------------------------------------------------------
module adc_strobe_timer #(
    parameter int PULSE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic low,
    output logic last_low,
    output logic done
);

    localparam int CNT_W = $clog2(2 * PULSE_CYC);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(2 * PULSE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || cnt == HIGH_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign low      = en && (cnt <= LOW_LAST);
    assign last_low = en && (cnt == LOW_LAST);
    assign done     = en && (cnt == HIGH_LAST);

endmodule

// File: rtl/adc_par_capture.sv
// -----------------------------------------------------------------------------
// adc_par_capture
//   Parallel-bus ADC front end. After reset it writes two configuration words
//   over the shared data bus, then on every sample tick (while run is high)
//   starts a conversion, waits for BUSY to pulse, reads N_CH channels and
//   delivers them as a valid/ready stream.
//
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     run                      enable periodic conversions
//     busy                     ADC BUSY (high while converting)
//     db[DATA_W]               bidirectional ADC bus, driven only while wr_n low
//     convst                   conversion start (all channel pairs)
//     cs_n, rd_n, wr_n         active-low ADC strobes
//     hw_n, par_n, stby_n      constant straps
//     m_data, m_chan, m_last   sample, channel index, final channel of frame
//     m_valid / m_ready        stream handshake
//     cfg_done                 configuration written (sticky)
//     missed                   saturating count of ticks seen outside IDLE
//     timeout_err              sticky BUSY timeout (only with the macro below)
//
//   Build option: define ADC_BUSY_TIMEOUT_EN to bound the BUSY waits to
//   BUSY_TIMEOUT_CYC cycles and add the timeout_err port.
// -----------------------------------------------------------------------------
module adc_par_capture
    import adc_pkg::*;
#(
    parameter int                N_CH       = 8,
    parameter int                DATA_W     = 16,
    parameter int                SAMPLE_DIV = 2000,
    parameter logic [DATA_W-1:0] CFG_HI     = 16'h8054,
    parameter logic [DATA_W-1:0] CFG_LO     = 16'h03FF,
    parameter int                PULSE_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              busy,
    inout  wire  [DATA_W-1:0] db,
    output logic              convst,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              hw_n,
    output logic              par_n,
    output logic              stby_n,
    output logic [DATA_W-1:0] m_data,
    output logic [2:0]        m_chan,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              cfg_done,
`ifdef ADC_BUSY_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic [15:0]       missed
);

    localparam int               TICK_W    = $clog2(SAMPLE_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [2:0]       LAST_CHAN = 3'(N_CH - 1);

    state_t state, state_next;

    logic              str_en, str_low, str_last_low, str_done;
    logic              cs_act, wr_act, rd_act, cv_act;
    logic [2:0]        chan;
    logic              chan_last;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              hs;
    logic              wait_expired;

    assign hw_n   = HW_N_STRAP;
    assign par_n  = PAR_N_STRAP;
    assign stby_n = STBY_N_STRAP;

    assign chan_last = (chan == LAST_CHAN);
    assign tick      = cfg_done && (tick_cnt == TICK_LAST);

    // The timer runs only in states that own a strobe; rst is folded in so
    // no strobe can assert while reset is held.
    assign str_en = rst && (state inside {CFG_W0, CFG_W1, CONV, RD});

    adc_strobe_timer #(
        .PULSE_CYC (PULSE_CYC)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .en       (str_en),
        .low      (str_low),
        .last_low (str_last_low),
        .done     (str_done)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CFG_W0;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cs_act     = 1'b0;
        wr_act     = 1'b0;
        rd_act     = 1'b0;
        cv_act     = 1'b0;
        unique case (state)
            CFG_W0: begin
                cs_act = 1'b1;
                wr_act = str_low;
                if (str_done) state_next = CFG_W1;
            end
            CFG_W1: begin
                cs_act = 1'b1;
                wr_act = str_low;
                if (str_done) state_next = IDLE;
            end
            IDLE: begin
                if (tick && run) state_next = CONV;
            end
            CONV: begin
                cs_act = 1'b1;
                cv_act = str_low;
                if (str_done) state_next = WAIT_HI;
            end
            WAIT_HI: begin
                cs_act = 1'b1;
                if (busy)              state_next = WAIT_LO;
                else if (wait_expired) state_next = IDLE;
            end
            WAIT_LO: begin
                cs_act = 1'b1;
                if (!busy)             state_next = RD;
                else if (wait_expired) state_next = IDLE;
            end
            RD: begin
                cs_act = 1'b1;
                rd_act = str_low;
                if (str_done) state_next = PUSH;
            end
            PUSH: begin
                cs_act = 1'b1;
                if (m_ready) state_next = chan_last ? IDLE : RD;
            end
            default: state_next = CFG_W0;
        endcase
    end

    assign cs_n    = ~(rst & cs_act);
    assign wr_n    = ~wr_act;
    assign rd_n    = ~rd_act;
    assign convst  = cv_act;
    assign m_valid = rst && (state == PUSH);
    assign m_last  = m_valid && chan_last;
    assign m_chan  = chan;
    assign hs      = m_valid && m_ready;

    // Only the configuration states ever drive the bus.
    assign db = wr_act ? ((state == CFG_W1) ? CFG_LO : CFG_HI) : {DATA_W{1'bz}};

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_done <= 1'b0;
            tick_cnt <= '0;
            missed   <= '0;
            m_data   <= '0;
            chan     <= '0;
        end else begin
            if (state == CFG_W1 && str_done) cfg_done <= 1'b1;

            if (cfg_done) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

            // A tick outside IDLE is dropped, never started late.
            if (tick && state != IDLE && missed != 16'hFFFF) missed <= missed + 1'b1;

            // Sample on the last RD_N-low cycle, when the ADC output has settled.
            if (state == RD && str_last_low) m_data <= db;

            if (state == WAIT_LO && !busy) begin
                chan <= '0;
            end else if (hs) begin
                chan <= chan_last ? '0 : chan + 1'b1;
            end
        end
    end

    // ------------------------------------------------------- BUSY timeout
`ifdef ADC_BUSY_TIMEOUT_EN
    logic [BUSY_TIMEOUT_W-1:0] wait_cnt;

    // One budget covers both the BUSY rise and the BUSY fall.
    assign wait_expired = (wait_cnt == BUSY_TIMEOUT_W'(BUSY_TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state inside {WAIT_HI, WAIT_LO}) wait_cnt <= wait_cnt + 1'b1;
            else                                 wait_cnt <= '0;
            if ((state inside {WAIT_HI, WAIT_LO}) && state_next == IDLE) timeout_err <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

endmodule

// File: tb/tb_adc_par_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_par_capture
//   Bench for adc_par_capture with a behavioural ADC: each CONVST rise makes a
//   fresh random frame, raises BUSY for a fixed time and serves one sample per
//   RD_N pulse. The expected stream is the frame in channel order, last flag
//   on the final channel. Inputs change 1 time unit after the rising edge,
//   outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_par_capture;

    localparam int N_CH       = 8;
    localparam int DATA_W     = 16;
    localparam int SAMPLE_DIV = 2000;
    localparam int PULSE      = 4;
    localparam int BUSY_CYC   = 50;
    localparam logic [15:0] CFG_HI = 16'h8054;
    localparam logic [15:0] CFG_LO = 16'h03FF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic m_ready = 1'b0;
    wire  busy;
    wire  [DATA_W-1:0] db;
    logic convst, cs_n, rd_n, wr_n, hw_n, par_n, stby_n;
    logic [DATA_W-1:0] m_data;
    logic [2:0] m_chan;
    logic m_last, m_valid, cfg_done;
    logic [15:0] missed;
`ifdef ADC_BUSY_TIMEOUT_EN
    logic timeout_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adc_par_capture #(
        .N_CH       (N_CH),
        .DATA_W     (DATA_W),
        .SAMPLE_DIV (SAMPLE_DIV),
        .CFG_HI     (CFG_HI),
        .CFG_LO     (CFG_LO),
        .PULSE_CYC  (PULSE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .busy        (busy),
        .db          (db),
        .convst      (convst),
        .cs_n        (cs_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .hw_n        (hw_n),
        .par_n       (par_n),
        .stby_n      (stby_n),
        .m_data      (m_data),
        .m_chan      (m_chan),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .cfg_done    (cfg_done),
`ifdef ADC_BUSY_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .missed      (missed)
    );

    // ------------------------------------------------------------ ADC model
    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  chan;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    logic [15:0] samples [N_CH];
    logic [2:0]  rd_idx     = '0;
    logic        convst_q   = 1'b0;
    logic        rd_q       = 1'b1;
    int          busy_timer = 0;
    logic        busy_block = 1'b0;
    int          conv_count = 0;
    int          overlap_cnt = 0;

    assign busy = (busy_timer != 0) && !busy_block;
    assign db   = (!cs_n && !rd_n) ? samples[rd_idx] : 16'hzzzz;

    task automatic new_frame();
        logic [15:0] s;
        for (int i = 0; i < N_CH; i++) begin
            s = 16'($urandom);
            samples[i] = s;
            exp_q.push_back({s, 3'(i), (i == N_CH - 1)});
        end
    endtask

    always @(posedge clk) begin
        convst_q <= convst;
        rd_q     <= rd_n;
        if (convst && !convst_q) begin
            busy_timer <= BUSY_CYC;
            rd_idx     <= '0;
            conv_count <= conv_count + 1;
            new_frame();
        end else begin
            if (busy_timer != 0) busy_timer <= busy_timer - 1;
            if (rd_n && !rd_q)   rd_idx <= rd_idx + 1'b1;
        end
    end

    // Stream and strobe monitor.
    always @(negedge clk) begin
        if (m_valid && m_ready) got_q.push_back({m_data, m_chan, m_last});
        if (!wr_n && !rd_n)     overlap_cnt <= overlap_cnt + 1;
    end

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        obs = {wr_n, rd_n, cs_n, convst, m_valid, m_last, cfg_done, hw_n, par_n, stby_n};
        n_tests++;
        if (obs !== 10'b1110000101) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required %b", obs, 10'b1110000101);
        end
        n_tests++;
        if ({m_data, m_chan, missed} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%h m_chan=%0d missed=%0d, required all 0",
                     m_data, m_chan, missed);
        end
    endtask

    task automatic test_config();
        logic [19:0] wr_obs, wr_exp, done_obs, done_exp;
        logic        low_exp;
        logic [15:0] word_exp;
        drive_step();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            low_exp   = (k < PULSE) || (k >= 2 * PULSE && k < 3 * PULSE);
            wr_exp[k] = ~low_exp;
            wr_obs[k] = wr_n;
            done_exp[k] = (k >= 4 * PULSE);
            done_obs[k] = cfg_done;
            if (low_exp) begin
                word_exp = (k < PULSE) ? CFG_HI : CFG_LO;
                n_tests++;
                if (db !== word_exp) begin
                    n_fail++;
                    $display("FAIL cfg_db cycle %0d: got %h, required %h", k, db, word_exp);
                end
            end
        end
        n_tests++;
        if (wr_obs !== wr_exp) begin
            n_fail++;
            $display("FAIL cfg_wr_n: got %b, required %b", wr_obs, wr_exp);
        end
        n_tests++;
        if (done_obs !== done_exp) begin
            n_fail++;
            $display("FAIL cfg_done: got %b, required %b", done_obs, done_exp);
        end
    endtask

    task automatic test_frame();
        int cyc = 0;
        drive_step();
        run = 1'b1;
        m_ready = 1'b1;
        while (got_q.size() < N_CH && cyc < 2 * SAMPLE_DIV + 500) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (got_q.size() < N_CH || exp_q.size() < N_CH) begin
            n_fail++;
            $display("FAIL frame_wait: got %0d beats, required %0d", got_q.size(), N_CH);
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            beat_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL frame beat %0d: got data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, g.data, g.chan, g.last, e.data, e.chan, e.last);
            end
        end
        n_tests++;
        if (missed !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_missed: got %0d, required 0", missed);
        end
    endtask

    task automatic test_back_pressure();
        int    cyc = 0;
        int    unstable = 0;
        beat_t held;
        while (got_q.size() < 3 && cyc < 2 * SAMPLE_DIV + 500) begin
            @(negedge clk);
            cyc++;
        end
        drive_step();
        m_ready = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (!m_valid) begin
            n_fail++;
            $display("FAIL bp_wait: m_valid=%b, required 1", m_valid);
            return;
        end
        held = {m_data, m_chan, m_last};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!m_valid || {m_data, m_chan, m_last} !== held) unstable++;
        end
        n_tests++;
        if (unstable != 0 || held.chan !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, held chan %0d, required 0 and chan 3",
                     unstable, held.chan);
        end
        drive_step();
        m_ready = 1'b1;
        cyc = 0;
        while (got_q.size() < N_CH && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (got_q.size() < N_CH || exp_q.size() < N_CH) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d beats, required %0d", got_q.size(), N_CH);
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            beat_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bp beat %0d: got data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, g.data, g.chan, g.last, e.data, e.chan, e.last);
            end
        end
        n_tests++;
        if (missed !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_missed: got %0d, required 1", missed);
        end
    endtask

    task automatic test_run_stop();
        int cyc = 0;
        int conv_before;
        while (got_q.size() < 3 && cyc < 2 * SAMPLE_DIV + 500) begin
            @(negedge clk);
            cyc++;
        end
        drive_step();
        run = 1'b0;
        cyc = 0;
        while (got_q.size() < N_CH && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (got_q.size() < N_CH || exp_q.size() < N_CH) begin
            n_fail++;
            $display("FAIL stop_drain: got %0d beats, required %0d", got_q.size(), N_CH);
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            beat_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL stop beat %0d: got data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, g.data, g.chan, g.last, e.data, e.chan, e.last);
            end
        end
        conv_before = conv_count;
        repeat (2 * SAMPLE_DIV + 500) @(negedge clk);
        n_tests++;
        if (conv_count != conv_before || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL stop_idle: %0d new conversions, %0d new beats, required 0 and 0",
                     conv_count - conv_before, got_q.size());
        end
        n_tests++;
        if (missed !== 16'd1) begin
            n_fail++;
            $display("FAIL stop_missed: got %0d, required 1", missed);
        end
    endtask

`ifdef ADC_BUSY_TIMEOUT_EN
    task automatic test_busy_timeout();
        int cyc = 0;
        drive_step();
        busy_block = 1'b1;
        run = 1'b1;
        while (!convst && cyc < 2 * SAMPLE_DIV + 500) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (!cs_n && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc != 2 * PULSE + 1024) begin
            n_fail++;
            $display("FAIL timeout_len: cs_n low %0d cycles after convst, required %0d",
                     cyc, 2 * PULSE + 1024);
        end
        n_tests++;
        if (timeout_err !== 1'b1 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_err: got %b with %0d beats, required 1 with 0 beats",
                     timeout_err, got_q.size());
        end
        drive_step();
        run = 1'b0;
        busy_block = 1'b0;
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_mid_rd();
        int cyc = 0;
        logic [4:0] obs;
        drive_step();
        run = 1'b1;
        while (rd_n && cyc < 2 * SAMPLE_DIV + 500) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (rd_n) begin
            n_fail++;
            $display("FAIL rstrd_wait: rd_n=%b, required 0", rd_n);
            return;
        end
        drive_step();
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obs = {wr_n, rd_n, cs_n, convst, m_valid};
        n_tests++;
        if (obs !== 5'b11100) begin
            n_fail++;
            $display("FAIL rstrd_strobes: got %b, required %b", obs, 5'b11100);
        end
        n_tests++;
        if ({cfg_done, missed, m_chan} !== 20'd0) begin
            n_fail++;
            $display("FAIL rstrd_state: cfg_done=%b missed=%0d m_chan=%0d, required all 0",
                     cfg_done, missed, m_chan);
        end
`ifdef ADC_BUSY_TIMEOUT_EN
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstrd_timeout_err: got %b, required 0", timeout_err);
        end
`endif
        repeat (3) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        test_config();
    endtask

    task automatic test_strobe_exclusive();
        n_tests++;
        if (overlap_cnt != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: wr_n and rd_n both low in %0d cycles, required 0",
                     overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_frame();
        test_back_pressure();
        test_run_stop();
`ifdef ADC_BUSY_TIMEOUT_EN
        test_busy_timeout();
`endif
        test_reset_mid_rd();
        test_strobe_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
